// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite master: one NONSEQ word transfer per command, response 3 cycles after accept.
// Zero-wait latency is 3 cycles; HREADY=0 stretches the address or data phase, and rsp_ready=0 holds the response.
module ahb_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0]        HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
    localparam logic [ADDR_W-1:0] WORD_MASK     = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          htrans_q, htrans_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic                hwrite_q, hwrite_d;
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_ADDR;
            S_ADDR:  if (HREADY)    state_d = S_DATA;
            S_DATA:  if (HREADY)    state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every registered output holds unless its phase completes on this edge.
    always_comb begin
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    wr_d     = cmd_write;
                    wdata_d  = cmd_wdata;
                    htrans_d = HTRANS_NONSEQ;
                    haddr_d  = cmd_addr & WORD_MASK;
                    hwrite_d = cmd_write;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    haddr_d  = '0;
                    hwrite_d = 1'b0;
                    hwdata_d = wr_q ? wdata_q : '0;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    rsp_rdata_d = wr_q ? '0 : HRDATA;
                    rsp_write_d = wr_q;
                    rsp_valid_d = 1'b1;
                    hwdata_d    = '0;
                end
            end
            S_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign HTRANS    = htrans_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = 3'b010;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
